// File: rtl/sar_adc_pkg.sv
// Shared types and widths for the SAR ADC controller slice.
package sar_adc_pkg;

  localparam int unsigned ADC_RES_W  = 8;
  localparam int unsigned ADC_NUM_CH = 6;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned BIT_W      = $clog2(ADC_RES_W);
  localparam int unsigned CNT_W      = 4;

  localparam logic [ADC_RES_W-1:0] MSB_CODE = ADC_RES_W'(1) << (ADC_RES_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CONV   = 2'd2,
    DONE   = 2'd3
  } sar_state_e;

  // Channel numbers beyond the mux width select nothing.
  function automatic logic [ADC_NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [ADC_NUM_CH-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < ADC_NUM_CH; i++) begin
      if (ch == CH_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/sar_comp_sync.sv
// Two-flop synchronizer bringing the analog comparator output into mclk.
module sar_comp_sync (
  input  logic mclk,
  input  logic reset,
  input  logic comp_in,
  output logic comp_s
);

  logic meta_q;

  always_ff @(posedge mclk) begin
    if (reset) begin
      meta_q <= 1'b0;
      comp_s <= 1'b0;
    end else begin
      meta_q <= comp_in;
      comp_s <= meta_q;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer: sample phase, 8-step binary search on the DAC, result hold
// until the requester drops start_conv.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned SAMPLE_CYC = 4
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  pulse1m_mclk,
  input  logic                  start_conv,
  input  logic [CH_W-1:0]       adc_ch_no,
  input  logic                  comp_in,
  output logic [ADC_RES_W-1:0]  dac_code,
  output logic                  sample_en,
  output logic [ADC_NUM_CH-1:0] an_ch_sel,
  output logic                  conv_done,
  output logic [ADC_RES_W-1:0]  adc_result
);

  sar_state_e           state;
  logic [CH_W-1:0]      ch_q;
  logic [CNT_W-1:0]     sample_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 comp_s;
  logic [ADC_RES_W-1:0] trial_code_c;

  sar_comp_sync u_comp_sync (
    .mclk    (mclk),
    .reset   (reset),
    .comp_in (comp_in),
    .comp_s  (comp_s)
  );

  // Resolve the current bit and arm the next lower one.
  always_comb begin
    trial_code_c = dac_code;
    if (!comp_s) trial_code_c[bit_idx] = 1'b0;
    if (bit_idx != '0) trial_code_c[bit_idx - BIT_W'(1)] = 1'b1;
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state      <= IDLE;
      ch_q       <= '0;
      sample_cnt <= '0;
      bit_idx    <= '0;
      dac_code   <= '0;
      sample_en  <= 1'b0;
      an_ch_sel  <= '0;
      conv_done  <= 1'b0;
      adc_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          dac_code  <= '0;
          sample_en <= 1'b0;
          an_ch_sel <= '0;
          conv_done <= 1'b0;
          if (pulse1m_mclk && start_conv) begin
            ch_q       <= adc_ch_no;
            sample_cnt <= '0;
            sample_en  <= 1'b1;
            an_ch_sel  <= ch_onehot(adc_ch_no);
            state      <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (!start_conv) begin
            state     <= IDLE;
            dac_code  <= '0;
            sample_en <= 1'b0;
            an_ch_sel <= '0;
          end else begin
            an_ch_sel <= ch_onehot(ch_q);
            if (pulse1m_mclk) begin
              sample_cnt <= sample_cnt + CNT_W'(1);
              if (sample_cnt == CNT_W'(SAMPLE_CYC - 1)) begin
                state     <= CONV;
                dac_code  <= MSB_CODE;
                bit_idx   <= BIT_W'(ADC_RES_W - 1);
                sample_en <= 1'b0;
                an_ch_sel <= '0;
              end
            end
          end
        end

        CONV: begin
          if (!start_conv) begin
            state    <= IDLE;
            dac_code <= '0;
          end else if (pulse1m_mclk) begin
            dac_code <= trial_code_c;
            if (bit_idx == '0) begin
              adc_result <= trial_code_c;
              conv_done  <= 1'b1;
              state      <= DONE;
            end else begin
              bit_idx <= bit_idx - BIT_W'(1);
            end
          end
        end

        DONE: begin
          // Leave on any low cycle of start_conv; a tick is not needed.
          if (!start_conv) begin
            state     <= IDLE;
            conv_done <= 1'b0;
            dac_code  <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator, random conversions against a binary-search model.
module tb_sar_adc_ctrl;

  localparam int SC = 2;

  logic       mclk;
  logic       reset;
  logic       pulse_1m;
  logic       start_conv;
  logic [2:0] adc_ch_no;
  logic       comp_in;
  logic [7:0] dac_code;
  logic       sample_en;
  logic [5:0] an_ch_sel;
  logic       conv_done;
  logic [7:0] adc_result;

  logic [7:0] vin_code;
  logic [7:0] exp_result;
  int         n_checks;
  int         n_fail;

  assign comp_in = (vin_code >= dac_code);

  sar_adc_ctrl #(.SAMPLE_CYC(SC)) dut (
    .mclk         (mclk),
    .reset        (reset),
    .pulse1m_mclk (pulse_1m),
    .start_conv   (start_conv),
    .adc_ch_no    (adc_ch_no),
    .comp_in      (comp_in),
    .dac_code     (dac_code),
    .sample_en    (sample_en),
    .an_ch_sel    (an_ch_sel),
    .conv_done    (conv_done),
    .adc_result   (adc_result)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // One-cycle tick every 10 mclk.
  initial begin
    pulse_1m = 1'b0;
    forever begin
      repeat (9) @(negedge mclk);
      pulse_1m = 1'b1;
      @(negedge mclk);
      pulse_1m = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Trial k of an ideal binary search: resolved top k bits of vin plus the probe bit.
  function automatic logic [7:0] exp_trial(input logic [7:0] vin, input int k);
    int mask;
    mask = 256 - (256 >> k);
    return 8'((int'(vin) & mask) | (128 >> k));
  endfunction

  function automatic logic [5:0] exp_sel(input int ch);
    return (ch < 6) ? 6'(1 << ch) : 6'd0;
  endfunction

  task automatic run_conv(input logic [2:0] ch, input logic [7:0] vin);
    int t;
    adc_ch_no  = ch;
    vin_code   = vin;
    start_conv = 1'b1;
    t = -1;
    for (int c = 0; c < 300 && t < SC + 8; c++) begin
      @(posedge mclk); #1;
      if (pulse_1m) begin
        t++;
        if (t == 0) begin
          check("sample_en_on", 32'(sample_en), 32'd1);
          check("an_ch_sel", 32'(an_ch_sel), 32'(exp_sel(int'(ch))));
          check("done_low_sample", 32'(conv_done), 32'd0);
        end else if (t >= SC && t < SC + 8) begin
          check("dac_trial", 32'(dac_code), 32'(exp_trial(vin, t - SC)));
          check("done_early", 32'(conv_done), 32'd0);
          if (t == SC) begin
            check("sample_en_off", 32'(sample_en), 32'd0);
            check("an_ch_sel_off", 32'(an_ch_sel), 32'd0);
          end
        end else if (t == SC + 8) begin
          check("conv_done", 32'(conv_done), 32'd1);
          check("adc_result", 32'(adc_result), 32'(vin));
          check("dac_final", 32'(dac_code), 32'(vin));
          exp_result = vin;
        end
      end
    end
    if (t < SC + 8) check("conv_timeout", 32'(t), 32'(SC + 8));
  endtask

  // Drop start_conv for one cycle chosen on or off a tick, then expect IDLE.
  task automatic release_start(input bit on_tick);
    bit found;
    found = 1'b0;
    check("done_hold", 32'(conv_done), 32'd1);
    check("result_hold", 32'(adc_result), 32'(exp_result));
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge mclk); #1;
      if (pulse_1m == on_tick) found = 1'b1;
    end
    if (!found) check("release_timeout", 32'd0, 32'd1);
    start_conv = 1'b0;
    @(posedge mclk); #1;
    check("rel_done_low", 32'(conv_done), 32'd0);
    check("rel_dac_zero", 32'(dac_code), 32'd0);
    check("rel_sample_off", 32'(sample_en), 32'd0);
    check("rel_result_kept", 32'(adc_result), 32'(exp_result));
  endtask

  task automatic do_reset();
    @(negedge mclk);
    reset = 1'b1;
    @(posedge mclk); #1;
    check("rst_dac", 32'(dac_code), 32'd0);
    check("rst_sample_en", 32'(sample_en), 32'd0);
    check("rst_an_ch_sel", 32'(an_ch_sel), 32'd0);
    check("rst_done", 32'(conv_done), 32'd0);
    check("rst_result", 32'(adc_result), 32'd0);
    @(negedge mclk);
    reset      = 1'b0;
    start_conv = 1'b0;
    exp_result = 8'h00;
  endtask

  task automatic abort_at_bit4(input logic [2:0] ch, input logic [7:0] vin);
    int  t;
    bit  seen_done;
    adc_ch_no  = ch;
    vin_code   = vin;
    start_conv = 1'b1;
    t = -1;
    for (int c = 0; c < 300 && t < SC + 3; c++) begin
      @(posedge mclk); #1;
      if (pulse_1m) t++;
    end
    if (t < SC + 3) check("abort_timeout", 32'(t), 32'(SC + 3));
    check("abort_trial_b4", 32'(dac_code), 32'(exp_trial(vin, 3)));
    @(negedge mclk); #1;
    start_conv = 1'b0;
    @(posedge mclk); #1;
    check("abort_dac_zero", 32'(dac_code), 32'd0);
    check("abort_done_low", 32'(conv_done), 32'd0);
    check("abort_result_kept", 32'(adc_result), 32'(exp_result));
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge mclk); #1;
      if (conv_done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    start_conv = 1'b0;
    adc_ch_no  = 3'd0;
    vin_code   = 8'h00;
    exp_result = 8'h00;
    repeat (3) @(posedge mclk);
    #1;
    check("init_dac", 32'(dac_code), 32'd0);
    check("init_sample_en", 32'(sample_en), 32'd0);
    check("init_an_ch_sel", 32'(an_ch_sel), 32'd0);
    check("init_done", 32'(conv_done), 32'd0);
    check("init_result", 32'(adc_result), 32'd0);
    @(negedge mclk);
    reset = 1'b0;

    run_conv(3'd3, 8'hA5);
    release_start(1'b0);
    run_conv(3'd4, 8'h00);
    release_start(1'b0);
    run_conv(3'd5, 8'hFF);
    release_start(1'b0);
    run_conv(3'd0, 8'($urandom_range(0, 255)));
    release_start(1'b0);
    run_conv(3'd1, 8'($urandom_range(0, 255)));
    release_start(1'b1);
    run_conv(3'd2, 8'($urandom_range(0, 255)));
    release_start(1'b0);

    abort_at_bit4(3'd2, 8'h5C);

    run_conv(3'd6, 8'h3C);
    release_start(1'b0);

    for (int i = 0; i < 8; i++) begin
      run_conv(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      release_start(1'($urandom_range(0, 1)));
    end

    // Reset while sampling.
    adc_ch_no  = 3'd1;
    vin_code   = 8'h77;
    start_conv = 1'b1;
    for (int c = 0; c < 30 && !sample_en; c++) begin
      @(posedge mclk); #1;
    end
    check("pre_rst_sampling", 32'(sample_en), 32'd1);
    do_reset();

    run_conv(3'd4, 8'h9E);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
